// File: rtl/vi_stats_latch_resp.sv
// Interval stats latch/clear responder (stats clock domain).
// A latch request copies the live event counters into a shadow bank and
// restarts the live counters in the same cycle. A fixed delay later a single
// done pulse is returned to the initiator. Software reads the frozen shadow
// values through a registered read port.
module vi_stats_latch_resp #(
  parameter int NUM_CNT    = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int DONE_DLY   = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  latch_req_pulse,
  input  logic [NUM_CNT-1:0]    cnt_inc,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_sat,
  output logic                  latch_done_pulse,
  output logic                  latch_busy,
  output logic                  latch_ovr_level,
  output logic [7:0]            interval_num
);

  localparam int DLY_W = (DONE_DLY > 1) ? $clog2(DONE_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DONE_DLY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           inum_q, inum_d;

  logic [CNT_WIDTH-1:0] live_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] live_d [NUM_CNT];
  logic [NUM_CNT-1:0]   live_sat_q, live_sat_d;
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_CNT];
  logic [NUM_CNT-1:0]   shadow_sat_q, shadow_sat_d;

  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_sat_q, rd_sat_d;

  logic                 accept;

  // A request is only taken while idle; requests during WAIT are dropped.
  assign accept = (state_q == ST_IDLE) && latch_req_pulse;

  // Handshake FSM next-state: delay countdown, busy/done, overrun flag, interval count.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    inum_d  = inum_q;
    case (state_q)
      ST_IDLE: begin
        if (latch_req_pulse) begin
          state_d = ST_WAIT;
          dly_d   = DLY_LOAD;
          busy_d  = 1'b1;
          // With a one-cycle delay the pulse coincides with the first WAIT cycle.
          done_d  = (DLY_LOAD == '0);
          inum_d  = inum_q + 8'd1;
          ovr_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (latch_req_pulse) begin
          ovr_d = 1'b1;
        end
        if (dly_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          dly_d  = dly_q - DLY_W'(1);
          // Registered pulse: asserted for the cycle in which the counter reads 0.
          done_d = (dly_q == DLY_W'(1));
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Handshake FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      inum_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      inum_q  <= inum_d;
    end
  end

  // Live counters saturate; on an accepted latch they are frozen into the shadow
  // bank and restart from this cycle's increment so no event is lost or doubled.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      live_d[i]       = live_q[i];
      live_sat_d[i]   = live_sat_q[i];
      shadow_d[i]     = shadow_q[i];
      shadow_sat_d[i] = shadow_sat_q[i];
      if (accept) begin
        shadow_d[i]     = live_q[i];
        shadow_sat_d[i] = live_sat_q[i];
        live_d[i]       = CNT_WIDTH'(cnt_inc[i]);
        live_sat_d[i]   = 1'b0;
      end else if (cnt_inc[i]) begin
        if (live_q[i] != CNT_MAX) begin
          live_d[i] = live_q[i] + CNT_WIDTH'(1);
        end
        if (live_d[i] == CNT_MAX) begin
          live_sat_d[i] = 1'b1;
        end
      end
    end
  end

  // Live and shadow counter banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      live_sat_q   <= '0;
      shadow_sat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      live_sat_q   <= live_sat_d;
      shadow_sat_q <= shadow_sat_d;
    end
  end

  // Read mux over the pre-update shadow bank; out-of-range indices read as zero.
  always_comb begin
    rd_data_d = '0;
    rd_sat_d  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_data_d = shadow_q[i];
        rd_sat_d  = shadow_sat_q[i];
      end
    end
  end

  // Registered read port, one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_sat_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_sat_q  <= rd_sat_d;
    end
  end

  assign rd_data          = rd_data_q;
  assign rd_sat           = rd_sat_q;
  assign latch_done_pulse = done_q;
  assign latch_busy       = busy_q;
  assign latch_ovr_level  = ovr_q;
  assign interval_num     = inum_q;

endmodule
